// File: rtl/oport_rr_arb_if.sv
// Handshake and data bundle between the input-buffer controllers / downstream
// node (master side) and the output-port arbiter (slave side).
interface oport_rr_arb_if #(
    parameter int PYLD_W = 23
) ();
    logic [4:0]          req;
    logic [5*PYLD_W-1:0] payload_i;
    logic [4:0]          gnt;
    logic                acc_rdy;
    logic                obuf_vld;
    logic                obuf_rdy;
    logic [PYLD_W-1:0]   obuf_data;

    modport slave (
        input  req, payload_i, obuf_rdy,
        output gnt, acc_rdy, obuf_vld, obuf_data
    );

    modport master (
        output req, payload_i, obuf_rdy,
        input  gnt, acc_rdy, obuf_vld, obuf_data
    );
endinterface

// File: rtl/oport_rr_arb.sv
// Output-port arbiter for one router direction. Round-robins five input
// requests into a one-entry output stage; when the downstream port is disabled
// it sinks requests and counts the discarded flits.
module oport_rr_arb #(
    parameter int PYLD_W = 23,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    oport_rr_arb_if.slave    bus,
    input  logic             port_dis,
    input  logic             cnt_clr,
    output logic             drain_act,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {NORM = 2'd0, DRAIN = 2'd1, RECOV = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [2:0]        ptr;
    logic              vld_q;
    logic [PYLD_W-1:0] data_q;

    logic [9:0]        req_sh;
    logic [4:0]        req_rot;
    logic              hit;
    logic [2:0]        off;
    logic [3:0]        win_sum;
    logic [2:0]        win;
    logic [4:0]        gnt_c;
    logic              acc_c;
    logic              xfer;
    logic [PYLD_W-1:0] pay_sel;
    logic [1:0]        inc;
    logic [CNT_W:0]    cnt_sum;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, map back.
    always_comb begin
        req_sh  = {bus.req, bus.req} >> ptr;
        req_rot = req_sh[4:0];
        hit     = 1'b0;
        off     = 3'd0;
        for (int j = 4; j >= 0; j--) begin
            if (req_rot[j]) begin
                hit = 1'b1;
                off = 3'(j);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, off};
        win     = (win_sum >= 4'd5) ? 3'(win_sum - 4'd5) : win_sum[2:0];
        gnt_c   = (hit && rst_n) ? (5'b00001 << win) : 5'b00000;
    end

    // Accept strobe: backpressure in NORM, always sink in DRAIN, closed in RECOV.
    always_comb begin
        acc_c = 1'b0;
        if (rst_n) begin
            case (state)
                NORM:    acc_c = ~vld_q | bus.obuf_rdy;
                DRAIN:   acc_c = 1'b1;
                default: acc_c = 1'b0;
            endcase
        end
    end

    // Next state: one step per cycle, NORM -> DRAIN -> RECOV -> NORM.
    always_comb begin
        state_nxt = state;
        case (state)
            NORM:    if (port_dis)  state_nxt = DRAIN;
            DRAIN:   if (!port_dis) state_nxt = RECOV;
            default: state_nxt = NORM;
        endcase
    end

    // Winner payload mux.
    always_comb begin
        pay_sel = '0;
        for (int i = 0; i < 5; i++) begin
            if (win == 3'(i)) pay_sel = bus.payload_i[i*PYLD_W +: PYLD_W];
        end
    end

    assign xfer = (|gnt_c) & acc_c;

    // State, round-robin pointer and output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= NORM;
            ptr    <= 3'd0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) ptr <= (win == 3'd4) ? 3'd0 : win + 3'd1;
            case (state)
                NORM: begin
                    if (xfer) begin
                        data_q <= pay_sel;
                        vld_q  <= 1'b1;
                    end else if (bus.obuf_rdy) begin
                        vld_q  <= 1'b0;
                    end
                end
                // A flit still held on the first DRAIN cycle is dropped (and counted).
                DRAIN:   vld_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Drops this cycle: held flit at drain entry plus any sunk transfer.
    always_comb begin
        inc     = (state == DRAIN) ? ({1'b0, vld_q} + {1'b0, xfer}) : 2'd0;
        cnt_sum = {1'b0, drop_cnt} + (CNT_W+1)'(inc);
    end

    // Saturating drop counter; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) drop_cnt <= '0;
        else if (cnt_sum[CNT_W]) drop_cnt <= '1;
        else drop_cnt <= cnt_sum[CNT_W-1:0];
    end

    assign bus.gnt       = gnt_c;
    assign bus.acc_rdy   = acc_c;
    assign bus.obuf_vld  = vld_q & (state != DRAIN);
    assign bus.obuf_data = data_q;
    assign drain_act     = (state == DRAIN);

endmodule
